// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one simple-dual-port BRAM (1-cycle read, read-first)
// between two requesters with independent round-robin arbitration on the read
// and write ports, and provides a sequencer that clears every address to zero.
// Optional feature macro: BRAM_ARB_FWD_EN (write-first forwarding on a same-cycle
// read/write collision; undefined = read-first, old data returned).
module bram_port_arbiter #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 11
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     rd_valid_0,
    input  logic                     rd_valid_1,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr_0,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr_1,
    output logic                     rd_ready_0,
    output logic                     rd_ready_1,
    output logic                     rsp_valid_0,
    output logic                     rsp_valid_1,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    input  logic                     wr_valid_0,
    input  logic                     wr_valid_1,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr_0,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr_1,
    input  logic [DATA_WIDTH-1:0]    wr_data_0,
    input  logic [DATA_WIDTH-1:0]    wr_data_1,
    output logic                     wr_ready_0,
    output logic                     wr_ready_1,
    input  logic                     clear_start,
    output logic                     clear_busy,
    output logic                     clear_done,
    output logic [ADDRESS_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0]    mem_dout,
    output logic                     mem_wen,
    output logic [ADDRESS_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0]    mem_din
);

    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] clear_cnt;
    logic          rd_pri;
    logic          wr_pri;
    logic [AW-1:0] raddr_q;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, round-robin grants and BRAM pin muxing
    always_comb begin
        state_next = state;
        rd_ready_0 = 1'b0;
        rd_ready_1 = 1'b0;
        wr_ready_0 = 1'b0;
        wr_ready_1 = 1'b0;
        mem_raddr  = raddr_q;
        mem_wen    = 1'b0;
        mem_waddr  = '0;
        mem_din    = '0;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next = CLEAR;
                end
                // Preferred requester wins if valid, else the other one
                rd_ready_0 = rd_valid_0 && (!rd_pri || !rd_valid_1);
                rd_ready_1 = rd_valid_1 && !rd_ready_0;
                wr_ready_0 = wr_valid_0 && (!wr_pri || !wr_valid_1);
                wr_ready_1 = wr_valid_1 && !wr_ready_0;
                if (rd_ready_0) begin
                    mem_raddr = rd_addr_0;
                end else if (rd_ready_1) begin
                    mem_raddr = rd_addr_1;
                end
                if (wr_ready_0) begin
                    mem_wen   = 1'b1;
                    mem_waddr = wr_addr_0;
                    mem_din   = wr_data_0;
                end else if (wr_ready_1) begin
                    mem_wen   = 1'b1;
                    mem_waddr = wr_addr_1;
                    mem_din   = wr_data_1;
                end
            end
            CLEAR: begin
                mem_wen   = 1'b1;
                mem_waddr = clear_cnt;
                if (clear_cnt == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Clear counter, done pulse, arbitration pointers and read response
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clear_cnt   <= '0;
            clear_done  <= 1'b0;
            rd_pri      <= 1'b0;
            wr_pri      <= 1'b0;
            raddr_q     <= '0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                clear_cnt <= clear_cnt + AW'(1);
            end else if (clear_start) begin
                clear_cnt <= '0;
            end
            clear_done <= (state == CLEAR) && (state_next == IDLE);
            if (rd_ready_0) begin
                rd_pri <= 1'b1;
            end else if (rd_ready_1) begin
                rd_pri <= 1'b0;
            end
            if (wr_ready_0) begin
                wr_pri <= 1'b1;
            end else if (wr_ready_1) begin
                wr_pri <= 1'b0;
            end
            raddr_q     <= mem_raddr;
            rsp_valid_0 <= rd_ready_0;
            rsp_valid_1 <= rd_ready_1;
        end
    end

    assign clear_busy = (state == CLEAR);

`ifdef BRAM_ARB_FWD_EN
    logic          fwd_hit_q;
    logic [DW-1:0] fwd_data_q;

    // Capture write data when a granted read hits the address being written
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q  <= (rd_ready_0 || rd_ready_1) && mem_wen && (mem_raddr == mem_waddr);
            fwd_data_q <= mem_din;
        end
    end

    // Response data: forwarded write data on a collision, BRAM output otherwise
    always_comb begin
        rsp_data = '0;
        if (rsp_valid_0 || rsp_valid_1) begin
            rsp_data = fwd_hit_q ? fwd_data_q : mem_dout;
        end
    end
`else
    // Response data: BRAM output while a response is valid (old data on collision)
    always_comb begin
        rsp_data = '0;
        if (rsp_valid_0 || rsp_valid_1) begin
            rsp_data = mem_dout;
        end
    end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter with a small behavioural read-first BRAM.
module tb_bram_port_arbiter;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 16;
    localparam int          DEPTH = 1 << AW;
`ifdef BRAM_ARB_FWD_EN
    localparam logic [DW-1:0] COLL_EXP = 16'hBEEF;
`else
    localparam logic [DW-1:0] COLL_EXP = 16'h1234;
`endif

    logic          clock;
    logic          reset_n;
    logic          rd_valid_0, rd_valid_1;
    logic [AW-1:0] rd_addr_0, rd_addr_1;
    logic          rd_ready_0, rd_ready_1;
    logic          rsp_valid_0, rsp_valid_1;
    logic [DW-1:0] rsp_data;
    logic          wr_valid_0, wr_valid_1;
    logic [AW-1:0] wr_addr_0, wr_addr_1;
    logic [DW-1:0] wr_data_0, wr_data_1;
    logic          wr_ready_0, wr_ready_1;
    logic          clear_start, clear_busy, clear_done;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_dout;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_din;

    int checks = 0;
    int errors = 0;

    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
        .rd_ready_0(rd_ready_0), .rd_ready_1(rd_ready_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1), .rsp_data(rsp_data),
        .wr_valid_0(wr_valid_0), .wr_valid_1(wr_valid_1),
        .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1),
        .wr_data_0(wr_data_0), .wr_data_1(wr_data_1),
        .wr_ready_0(wr_ready_0), .wr_ready_1(wr_ready_1),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_raddr(mem_raddr), .mem_dout(mem_dout),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_din(mem_din)
    );

    // Behavioural simple-dual-port BRAM, 1-cycle read, read-first
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (mem_wen) mem[mem_waddr] <= mem_din;
        mem_dout <= mem[mem_raddr];
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic          rv0, rv1;
        logic [AW-1:0] ra0, ra1;
        logic          wv0, wv1;
        logic [AW-1:0] wa0, wa1;
        logic [DW-1:0] wd0, wd1;
        logic          e_rr0, e_rr1, e_wr0, e_wr1, e_rsp0, e_rsp1;
        logic [DW-1:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic rv0, input logic rv1, input logic [AW-1:0] ra0,
                                input logic [AW-1:0] ra1, input logic wv0, input logic wv1,
                                input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                                input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                                input logic err0, input logic err1, input logic ewr0,
                                input logic ewr1, input logic ersp0, input logic ersp1,
                                input logic [DW-1:0] edata);
        vec_t v;
        v.rv0 = rv0; v.rv1 = rv1; v.ra0 = ra0; v.ra1 = ra1;
        v.wv0 = wv0; v.wv1 = wv1; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
        v.e_rr0 = err0; v.e_rr1 = err1; v.e_wr0 = ewr0; v.e_wr1 = ewr1;
        v.e_rsp0 = ersp0; v.e_rsp1 = ersp1; v.e_data = edata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rd_valid_0 = 0; rd_valid_1 = 0; rd_addr_0 = '0; rd_addr_1 = '0;
        wr_valid_0 = 0; wr_valid_1 = 0; wr_addr_0 = '0; wr_addr_1 = '0;
        wr_data_0 = '0; wr_data_1 = '0; clear_start = 0;
    endtask

    // Single read through requester 0; checks the response one cycle later
    task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        @(posedge clock); #1;
        rd_valid_0 = 1; rd_addr_0 = a;
        @(posedge clock); #1;
        rd_valid_0 = 0;
        @(negedge clock);
        check({name, "_valid"}, rsp_valid_0, 1);
        check({name, "_data"}, rsp_data, exp);
    endtask

    // Called after clear_start was driven in an IDLE cycle; runs through the sweep
    // with competing requests held high and optionally re-pulses clear_start.
    task automatic run_clear(input int repulse_k, output int busy_cnt, output int done_cnt,
                             output int done_k, output int ready_bad,
                             output logic rsp0_k0, output logic [DW-1:0] data_k0);
        busy_cnt = 0; done_cnt = 0; done_k = -1; ready_bad = 0;
        rsp0_k0 = 0; data_k0 = '0;
        @(posedge clock); #1;
        for (int k = 0; k <= DEPTH + 3; k++) begin
            if (k > 0) begin @(posedge clock); #1; end
            clear_start = (k == repulse_k);
            rd_valid_0  = 0;
            wr_valid_1  = 0;
            rd_valid_1  = (k < DEPTH - 2); rd_addr_1 = 6'h3F;
            wr_valid_0  = (k < DEPTH - 2); wr_addr_0 = 6'h3F; wr_data_0 = 16'hDEAD;
            @(negedge clock);
            if (k == 0) begin rsp0_k0 = rsp_valid_0; data_k0 = rsp_data; end
            if (clear_busy) begin
                busy_cnt++;
                if (rd_ready_0 || rd_ready_1 || wr_ready_0 || wr_ready_1) ready_bad++;
            end
            if (clear_done) begin done_cnt++; done_k = k; end
        end
        idle_inputs();
    endtask

    vec_t tbl[18];

    initial begin
        int busy_cnt, done_cnt, done_k, ready_bad, late_done, late_busy;
        logic rsp0_k0;
        logic [DW-1:0] data_k0;

        // rv rv ra ra wv wv wa wa wd wd | rr0 rr1 wr0 wr1 rsp0 rsp1 data
        tbl[0]  = mk(0,0,6'h00,6'h00, 1,0,6'h10,6'h00,16'hA010,16'h0000, 0,0,1,0, 0,0,16'h0000);
        tbl[1]  = mk(0,0,6'h00,6'h00, 1,1,6'h20,6'h05,16'hA020,16'h1234, 0,0,0,1, 0,0,16'h0000);
        tbl[2]  = mk(0,0,6'h00,6'h00, 1,1,6'h20,6'h05,16'hA020,16'h1234, 0,0,1,0, 0,0,16'h0000);
        tbl[3]  = mk(1,1,6'h10,6'h20, 0,0,6'h00,6'h00,16'h0000,16'h0000, 1,0,0,0, 0,0,16'h0000);
        tbl[4]  = mk(1,1,6'h10,6'h20, 0,0,6'h00,6'h00,16'h0000,16'h0000, 0,1,0,0, 1,0,16'hA010);
        tbl[5]  = mk(1,1,6'h10,6'h20, 0,0,6'h00,6'h00,16'h0000,16'h0000, 1,0,0,0, 0,1,16'hA020);
        tbl[6]  = mk(1,1,6'h10,6'h20, 0,0,6'h00,6'h00,16'h0000,16'h0000, 0,1,0,0, 1,0,16'hA010);
        tbl[7]  = mk(0,0,6'h00,6'h00, 0,0,6'h00,6'h00,16'h0000,16'h0000, 0,0,0,0, 0,1,16'hA020);
        tbl[8]  = mk(0,0,6'h00,6'h00, 0,1,6'h00,6'h30,16'h0000,16'h0030, 0,0,0,1, 0,0,16'h0000);
        tbl[9]  = mk(0,0,6'h00,6'h00, 0,1,6'h00,6'h30,16'h0000,16'h0030, 0,0,0,1, 0,0,16'h0000);
        tbl[10] = mk(0,0,6'h00,6'h00, 0,1,6'h00,6'h30,16'h0000,16'h0030, 0,0,0,1, 0,0,16'h0000);
        tbl[11] = mk(0,0,6'h00,6'h00, 1,1,6'h31,6'h30,16'h0031,16'h0030, 0,0,1,0, 0,0,16'h0000);
        tbl[12] = mk(1,0,6'h05,6'h00, 1,0,6'h05,6'h00,16'hBEEF,16'h0000, 1,0,1,0, 0,0,16'h0000);
        tbl[13] = mk(0,0,6'h00,6'h00, 0,0,6'h00,6'h00,16'h0000,16'h0000, 0,0,0,0, 1,0,COLL_EXP);
        tbl[14] = mk(0,1,6'h00,6'h05, 0,0,6'h00,6'h00,16'h0000,16'h0000, 0,1,0,0, 0,0,16'h0000);
        tbl[15] = mk(0,0,6'h00,6'h00, 0,0,6'h00,6'h00,16'h0000,16'h0000, 0,0,0,0, 0,1,16'hBEEF);
        tbl[16] = mk(0,1,6'h00,6'h30, 0,0,6'h00,6'h00,16'h0000,16'h0000, 0,1,0,0, 0,0,16'h0000);
        tbl[17] = mk(0,0,6'h00,6'h00, 0,0,6'h00,6'h00,16'h0000,16'h0000, 0,0,0,0, 0,1,16'h0030);

        // Reset state
        reset_n = 0;
        idle_inputs();
        repeat (3) @(negedge clock);
        check("reset_rsp_valid_0", rsp_valid_0, 0);
        check("reset_rsp_valid_1", rsp_valid_1, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_clear_busy", clear_busy, 0);
        check("reset_clear_done", clear_done, 0);
        @(posedge clock); #1;
        reset_n = 1;

        // Arbitration, responses and collision vectors
        for (int i = 0; i < 18; i++) begin
            @(posedge clock); #1;
            rd_valid_0 = tbl[i].rv0; rd_valid_1 = tbl[i].rv1;
            rd_addr_0  = tbl[i].ra0; rd_addr_1  = tbl[i].ra1;
            wr_valid_0 = tbl[i].wv0; wr_valid_1 = tbl[i].wv1;
            wr_addr_0  = tbl[i].wa0; wr_addr_1  = tbl[i].wa1;
            wr_data_0  = tbl[i].wd0; wr_data_1  = tbl[i].wd1;
            @(negedge clock);
            check($sformatf("v%0d_rd_ready_0", i), rd_ready_0, tbl[i].e_rr0);
            check($sformatf("v%0d_rd_ready_1", i), rd_ready_1, tbl[i].e_rr1);
            check($sformatf("v%0d_wr_ready_0", i), wr_ready_0, tbl[i].e_wr0);
            check($sformatf("v%0d_wr_ready_1", i), wr_ready_1, tbl[i].e_wr1);
            check($sformatf("v%0d_rsp_valid_0", i), rsp_valid_0, tbl[i].e_rsp0);
            check($sformatf("v%0d_rsp_valid_1", i), rsp_valid_1, tbl[i].e_rsp1);
            if (tbl[i].e_rsp0 || tbl[i].e_rsp1)
                check($sformatf("v%0d_rsp_data", i), rsp_data, tbl[i].e_data);
        end

        // Clear started in the same cycle as a granted read; clear_start re-pulsed mid-sweep
        @(posedge clock); #1;
        idle_inputs();
        rd_valid_0 = 1; rd_addr_0 = 6'h10; clear_start = 1;
        @(negedge clock);
        check("clr_start_rd_ready_0", rd_ready_0, 1);
        run_clear(5, busy_cnt, done_cnt, done_k, ready_bad, rsp0_k0, data_k0);
        check("clr_start_rsp_valid", rsp0_k0, 1);
        check("clr_start_rsp_data", data_k0, 16'hA010);
        check("clr1_busy_cycles", busy_cnt, DEPTH);
        check("clr1_done_count", done_cnt, 1);
        check("clr1_done_cycle", done_k, DEPTH);
        check("clr1_ready_while_busy", ready_bad, 0);
        for (int a = 0; a < DEPTH; a++)
            read_check(AW'(a), 16'h0000, $sformatf("clr1_rd_%0d", a));

        // Reset in the middle of a clear at counter value 7
        @(posedge clock); #1;
        wr_valid_0 = 1; wr_addr_0 = 6'h3F; wr_data_0 = 16'h5555;
        @(posedge clock); #1;
        wr_valid_0 = 0; clear_start = 1;
        @(posedge clock); #1;
        clear_start = 0;
        repeat (7) @(posedge clock);
        #2 reset_n = 0;
        #1;
        check("midrst_clear_busy", clear_busy, 0);
        check("midrst_clear_done", clear_done, 0);
        check("midrst_rsp_valid_0", rsp_valid_0, 0);
        check("midrst_rsp_valid_1", rsp_valid_1, 0);
        @(posedge clock); #1;
        reset_n = 1;
        @(posedge clock); #1;
        rd_valid_0 = 1; rd_valid_1 = 1; rd_addr_0 = 6'h01; rd_addr_1 = 6'h02;
        @(negedge clock);
        check("midrst_rd_pri_ready_0", rd_ready_0, 1);
        check("midrst_rd_pri_ready_1", rd_ready_1, 0);
        late_done = 0; late_busy = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            idle_inputs();
            @(negedge clock);
            if (clear_done) late_done++;
            if (clear_busy) late_busy++;
        end
        check("midrst_no_done", late_done, 0);
        check("midrst_no_busy", late_busy, 0);

        // Full clear after the interrupted one must reach the top address
        @(posedge clock); #1;
        clear_start = 1;
        @(negedge clock);
        run_clear(-1, busy_cnt, done_cnt, done_k, ready_bad, rsp0_k0, data_k0);
        check("clr2_busy_cycles", busy_cnt, DEPTH);
        check("clr2_done_count", done_cnt, 1);
        check("clr2_done_cycle", done_k, DEPTH);
        check("clr2_ready_while_busy", ready_bad, 0);
        read_check(6'h3F, 16'h0000, "clr2_rd_3f");
        read_check(6'h08, 16'h0000, "clr2_rd_08");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
